dmem_responder: RTL and testbench

- Data-memory responder for the core's `mem_d_*` port.
- Accepts read, write and cache-maintenance requests from the core's LSU/dcache side.
- Performs them against an internal word-addressed SRAM array and returns in-order tagged acknowledgements after a fixed latency.
- Sits opposite the core in the Icarus core testbench and is reusable as a simple TCM in small integrations.

---
 rtl/dmem_responder_if.sv | 34 +++
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the core (master) and the
// dmem_responder (slave).
interface dmem_responder_if;
  logic [31:0] mem_d_addr_w;
  logic [31:0] mem_d_data_wr_w;
  logic        mem_d_rd_w;
  logic [3:0]  mem_d_wr_w;
  logic        mem_d_cacheable_w;
  logic [10:0] mem_d_req_tag_w;
  logic        mem_d_invalidate_w;
  logic        mem_d_writeback_w;
  logic        mem_d_flush_w;
  logic        mem_d_accept_w;
  logic        mem_d_ack_w;
  logic        mem_d_error_w;
  logic [31:0] mem_d_data_rd_w;
  logic [10:0] mem_d_resp_tag_w;

  modport master (
    output mem_d_addr_w, mem_d_data_wr_w, mem_d_rd_w, mem_d_wr_w,
           mem_d_cacheable_w, mem_d_req_tag_w, mem_d_invalidate_w,
           mem_d_writeback_w, mem_d_flush_w,
    input  mem_d_accept_w, mem_d_ack_w, mem_d_error_w, mem_d_data_rd_w,
           mem_d_resp_tag_w
  );

  modport slave (
    input  mem_d_addr_w, mem_d_data_wr_w, mem_d_rd_w, mem_d_wr_w,
           mem_d_cacheable_w, mem_d_req_tag_w, mem_d_invalidate_w,
           mem_d_writeback_w, mem_d_flush_w,
    output mem_d_accept_w, mem_d_ack_w, mem_d_error_w, mem_d_data_rd_w,
           mem_d_resp_tag_w
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed SRAM with in-order tagged acks after a
// fixed LATENCY. Optional macro DMEM_RESP_STALL_EN gates accept with an LFSR.
module dmem_responder #(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef struct packed {
    logic        valid;
    logic [10:0] tag;
    logic [31:0] data;
    logic        err;
  } stage_t;

  logic [31:0]   mem_q [MEM_WORDS];
  stage_t        stage_q [LATENCY];
  stage_t        stage_d [LATENCY];
  stage_t        in_s    [LATENCY];
  stage_t        new_s;
  logic [AW-1:0] word_idx_s;
  logic          oor_s;
  logic          wr_any_s;
  logic          req_s;
  logic          take_s;
  logic          wr_en_s;
  logic          accept_q;
  logic          accept_d;
  logic          unused_s;

  assign unused_s = ^{bus.mem_d_cacheable_w, bus.mem_d_addr_w[1:0]};

  always_comb begin
    word_idx_s = bus.mem_d_addr_w[AW+1:2];
    oor_s      = |bus.mem_d_addr_w[31:AW+2];
    wr_any_s   = |bus.mem_d_wr_w;
    req_s      = bus.mem_d_rd_w | wr_any_s | bus.mem_d_invalidate_w |
                 bus.mem_d_writeback_w | bus.mem_d_flush_w;
    take_s     = req_s & accept_q;
    wr_en_s    = 1'b0;
    new_s.valid = take_s;
    new_s.tag   = bus.mem_d_req_tag_w;
    new_s.data  = 32'h0000_0000;
    new_s.err   = 1'b0;
    // Decode priority: range error, rd+wr conflict, write, read, maintenance.
    if (oor_s) begin
      new_s.err = 1'b1;
    end else if (bus.mem_d_rd_w && wr_any_s) begin
      new_s.err = 1'b1;
    end else if (wr_any_s) begin
      wr_en_s = take_s;
    end else if (bus.mem_d_rd_w) begin
      new_s.data = mem_q[word_idx_s];
    end else begin
      new_s.data = 32'h0000_0000;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_d_wr_w[b]) begin
          mem_q[word_idx_s][8*b +: 8] <= bus.mem_d_data_wr_w[8*b +: 8];
        end
      end
    end
  end

  // Every stage keeps tag/data when a bubble passes, so the last stage
  // naturally holds the previous response while ack is low.
  always_comb begin
    in_s[0] = new_s;
    for (int k = 1; k < LATENCY; k++) begin
      in_s[k] = stage_q[k-1];
    end
    for (int k = 0; k < LATENCY; k++) begin
      stage_d[k].valid = in_s[k].valid;
      stage_d[k].err   = in_s[k].valid & in_s[k].err;
      if (in_s[k].valid) begin
        stage_d[k].tag  = in_s[k].tag;
        stage_d[k].data = in_s[k].data;
      end else begin
        stage_d[k].tag  = stage_q[k].tag;
        stage_d[k].data = stage_q[k].data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < LATENCY; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < LATENCY; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

`ifdef DMEM_RESP_STALL_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Galois LFSR, taps 16,14,13,11; accept mirrors the inverted lsb.
  always_comb begin
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    accept_d = ~lfsr_d[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q   <= 16'hACE1;
      accept_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      accept_q <= accept_d;
    end
  end
`else
  always_comb begin
    accept_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      accept_q <= 1'b0;
    end else begin
      accept_q <= accept_d;
    end
  end
`endif

  assign bus.mem_d_accept_w   = accept_q;
  assign bus.mem_d_ack_w      = stage_q[LATENCY-1].valid;
  assign bus.mem_d_error_w    = stage_q[LATENCY-1].err;
  assign bus.mem_d_data_rd_w  = stage_q[LATENCY-1].data;
  assign bus.mem_d_resp_tag_w = stage_q[LATENCY-1].tag;

endmodule

// File: tb/tb_dmem_responder.sv
// Table-driven bench for dmem_responder with a cycle-stamped response scoreboard.
module tb_dmem_responder;
  localparam int LATENCY = 2;

  typedef struct {
    logic        rd;
    logic [3:0]  wr;
    logic [2:0]  maint;   // {flush, writeback, invalidate}
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [10:0] tag;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [10:0] tag;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  logic [31:0] last_data = 32'h0;
  logic [10:0] last_tag = 11'h0;
  vec_t vecs [18];

  dmem_responder_if bus ();

  dmem_responder #(.MEM_WORDS(4096), .LATENCY(LATENCY)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

`ifdef DMEM_RESP_STALL_EN
  logic [15:0] lfsr_ref;
  always @(posedge clk or negedge rst) begin
    if (!rst) lfsr_ref <= 16'hACE1;
    else      lfsr_ref <= {1'b0, lfsr_ref[15:1]} ^ (lfsr_ref[0] ? 16'hB400 : 16'h0000);
  end
`endif

  // Response monitor: pops expectations on ack, checks hold behaviour otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      last_data = 32'h0;
      last_tag  = 11'h0;
    end else if (bus.mem_d_ack_w) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got tag %h expected no ack", bus.mem_d_resp_tag_w);
      end else begin
        e = sb.pop_front();
        chk("ack_tag",   {21'h0, bus.mem_d_resp_tag_w}, {21'h0, e.tag});
        chk("ack_data",  bus.mem_d_data_rd_w, e.data);
        chk("ack_err",   {31'h0, bus.mem_d_error_w}, {31'h0, e.err});
        chk("ack_cycle", cyc, e.cyc);
        last_data = e.data;
        last_tag  = e.tag;
      end
    end else begin
      chk("idle_err",  {31'h0, bus.mem_d_error_w}, 32'h0);
      chk("hold_data", bus.mem_d_data_rd_w, last_data);
      chk("hold_tag",  {21'h0, bus.mem_d_resp_tag_w}, {21'h0, last_tag});
    end
`ifdef DMEM_RESP_STALL_EN
    chk("lfsr_accept", {31'h0, bus.mem_d_accept_w}, {31'h0, rst & ~lfsr_ref[0]});
`endif
  end

  task automatic set_idle();
    bus.mem_d_rd_w         = 1'b0;
    bus.mem_d_wr_w         = 4'h0;
    bus.mem_d_addr_w       = 32'h0;
    bus.mem_d_data_wr_w    = 32'h0;
    bus.mem_d_req_tag_w    = 11'h0;
    bus.mem_d_cacheable_w  = 1'b0;
    bus.mem_d_invalidate_w = 1'b0;
    bus.mem_d_writeback_w  = 1'b0;
    bus.mem_d_flush_w      = 1'b0;
  endtask

  // Presents one request and holds it until accept is seen mid-cycle.
  task automatic drive(input vec_t v);
    int  waited = 0;
    bit  taken = 0;
    while (!taken && waited < 50) begin
      @(negedge clk);
      bus.mem_d_rd_w         = v.rd;
      bus.mem_d_wr_w         = v.wr;
      bus.mem_d_addr_w       = v.addr;
      bus.mem_d_data_wr_w    = v.wdata;
      bus.mem_d_req_tag_w    = v.tag;
      bus.mem_d_cacheable_w  = 1'b1;
      bus.mem_d_invalidate_w = v.maint[0];
      bus.mem_d_writeback_w  = v.maint[1];
      bus.mem_d_flush_w      = v.maint[2];
      #1;
      if (bus.mem_d_accept_w) begin
        taken = 1;
        sb.push_back('{v.tag, v.exp_data, v.exp_err, cyc + LATENCY});
      end
      waited++;
    end
    if (!taken) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept expected accept for tag %h", v.tag);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    set_idle();
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    set_idle();
    // rd, wr, maint, addr, wdata, tag, exp_data, exp_err
    vecs[0]  = '{1'b0, 4'hF, 3'b000, 32'h0000_0100, 32'hDEAD_BEEF, 11'h001, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 4'h0, 3'b000, 32'h0000_0100, 32'h0000_0000, 11'h002, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 4'hF, 3'b000, 32'h0000_0200, 32'h0000_0000, 11'h003, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 4'hA, 3'b000, 32'h0000_0200, 32'h1122_3344, 11'h004, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b1, 4'h0, 3'b000, 32'h0000_0200, 32'h0000_0000, 11'h005, 32'h1100_3300, 1'b0};
    vecs[5]  = '{1'b0, 4'hF, 3'b000, 32'h0000_0000, 32'h1234_5678, 11'h006, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b0, 4'hF, 3'b000, 32'h0000_4000, 32'hCAFE_F00D, 11'h007, 32'h0000_0000, 1'b1};
    vecs[7]  = '{1'b1, 4'h0, 3'b000, 32'h0000_0000, 32'h0000_0000, 11'h008, 32'h1234_5678, 1'b0};
    vecs[8]  = '{1'b0, 4'hF, 3'b000, 32'h0000_0300, 32'hA5A5_A5A5, 11'h009, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b1, 4'h1, 3'b000, 32'h0000_0300, 32'hFFFF_FFFF, 11'h7FF, 32'h0000_0000, 1'b1};
    vecs[10] = '{1'b1, 4'h0, 3'b000, 32'h0000_0300, 32'h0000_0000, 11'h00A, 32'hA5A5_A5A5, 1'b0};
    vecs[11] = '{1'b0, 4'h5, 3'b000, 32'h0000_0100, 32'hAABB_CCDD, 11'h00B, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b1, 4'h0, 3'b000, 32'h0000_0100, 32'h0000_0000, 11'h00C, 32'hDEBB_BEDD, 1'b0};
    vecs[13] = '{1'b0, 4'h0, 3'b100, 32'h0000_0100, 32'h0000_0000, 11'h055, 32'h0000_0000, 1'b0};
    vecs[14] = '{1'b0, 4'h0, 3'b001, 32'h0000_0008, 32'h0000_0000, 11'h056, 32'h0000_0000, 1'b0};
    vecs[15] = '{1'b0, 4'h0, 3'b010, 32'h0000_0008, 32'h0000_0000, 11'h057, 32'h0000_0000, 1'b0};
    vecs[16] = '{1'b1, 4'h0, 3'b000, 32'hFFFF_FFFC, 32'h0000_0000, 11'h058, 32'h0000_0000, 1'b1};
    vecs[17] = '{1'b1, 4'h0, 3'b000, 32'h0000_4004, 32'h0000_0000, 11'h059, 32'h0000_0000, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_accept", {31'h0, bus.mem_d_accept_w}, 32'h0);
    chk("rst_ack",    {31'h0, bus.mem_d_ack_w}, 32'h0);
    chk("rst_err",    {31'h0, bus.mem_d_error_w}, 32'h0);
    chk("rst_data",   bus.mem_d_data_rd_w, 32'h0);
    chk("rst_tag",    {21'h0, bus.mem_d_resp_tag_w}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("accept_after_release", {31'h0, bus.mem_d_accept_w}, 32'h1);

    for (int i = 0; i < 18; i++) drive(vecs[i]);
    idle();
    drain();

    for (int i = 0; i < 8; i++) begin
      v = '{1'b1, 4'h0, 3'b000, 32'h0000_0100, 32'h0, 11'(i), 32'hDEBB_BEDD, 1'b0};
      drive(v);
    end
    idle();
    drain();

    // Reset while a read is in flight: the ack must never appear.
    v = '{1'b1, 4'h0, 3'b000, 32'h0000_0200, 32'h0, 11'h011, 32'h1100_3300, 1'b0};
    drive(v);
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    sb.delete();
    @(negedge clk);
    chk("midrst_accept", {31'h0, bus.mem_d_accept_w}, 32'h0);
    chk("midrst_ack",    {31'h0, bus.mem_d_ack_w}, 32'h0);
    chk("midrst_data",   bus.mem_d_data_rd_w, 32'h0);
    chk("midrst_tag",    {21'h0, bus.mem_d_resp_tag_w}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_accept_after", {31'h0, bus.mem_d_accept_w}, 32'h1);
    repeat (LATENCY + 3) @(negedge clk);

    v = '{1'b1, 4'h0, 3'b000, 32'h0000_0200, 32'h0, 11'h012, 32'h1100_3300, 1'b0};
    drive(v);
    idle();
    drain();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
